// File: rtl/dkong3_sndlatch_ctrl.sv
// dkong3_sndlatch_ctrl
// Main-CPU to sound-CPU command latch controller. Three per-port command
// FIFOs feed one shared latch bus through a round-robin arbiter and a
// four-phase strobe sequencer (IDLE -> SETUP -> STROBE -> HOLD).
// Optional feature macro: DK3_SNDLATCH_ACKWAIT_EN. When it is defined, a port
// that has been strobed is not served again until its sub CPU acknowledges.
`timescale 1ns/1ps

module dkong3_sndlatch_ctrl #(
    parameter int DEPTH      = 4,
    parameter int STROBE_LEN = 4
) (
    input  logic       I_CLK_24M,
    input  logic       I_RST,
    input  logic       I_MCPU_WR,
    input  logic [1:0] I_PORT_SEL,
    input  logic [7:0] I_MCPU_DO,
    input  logic [2:0] I_ACK,
    output logic [7:0] O_DATA,
    output logic [2:0] O_4E_Q,
    output logic [2:0] O_FULL,
    output logic [2:0] O_OVF,
    output logic       O_BUSY
);

    localparam int AW   = $clog2(DEPTH);
    localparam int CNTW = $clog2(STROBE_LEN) + 1;

    typedef enum logic [1:0] {IDLE, SETUP, STROBE, HOLD} state_t;

    state_t            state_reg, state_next;
    logic [CNTW-1:0]   cnt_reg, cnt_next;
    logic [1:0]        rr_reg, rr_next;
    logic [1:0]        gnt_reg, gnt_next;
    logic [7:0]        data_reg;

    logic [2:0]        empty;
    logic [2:0]        eligible;
    logic [2:0]        pop;
    logic [7:0]        head [3];
    logic              grant_valid;
    logic [1:0]        grant_idx;

    // Per-port command FIFOs
    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_fifo
            logic [7:0]    mem [DEPTH];
            logic [AW-1:0] wr_ptr_reg, rd_ptr_reg;
            logic [AW:0]   count_reg;
            logic          ovf_reg;
            logic          sel;
            logic          full;
            logic          push;

            assign sel  = I_MCPU_WR && (I_PORT_SEL == 2'(gi));
            assign full = (count_reg == (AW+1)'(DEPTH));
            // A write to a full FIFO is dropped even if the head pops on this edge
            assign push = sel && !full;

            // Storage array, no reset needed
            always_ff @(posedge I_CLK_24M) begin
                if (push) mem[wr_ptr_reg] <= I_MCPU_DO;
            end

            // Pointers, occupancy and sticky overflow
            always_ff @(posedge I_CLK_24M or posedge I_RST) begin
                if (I_RST) begin
                    wr_ptr_reg <= '0;
                    rd_ptr_reg <= '0;
                    count_reg  <= '0;
                    ovf_reg    <= 1'b0;
                end else begin
                    if (push)    wr_ptr_reg <= wr_ptr_reg + 1'b1;
                    if (pop[gi]) rd_ptr_reg <= rd_ptr_reg + 1'b1;
                    count_reg <= count_reg + (AW+1)'(push) - (AW+1)'(pop[gi]);
                    if (sel && full) ovf_reg <= 1'b1;
                end
            end

            assign empty[gi]  = (count_reg == '0);
            assign O_FULL[gi] = full;
            assign O_OVF[gi]  = ovf_reg;
            assign head[gi]   = mem[rd_ptr_reg];
        end
    endgenerate

`ifdef DK3_SNDLATCH_ACKWAIT_EN
    logic [2:0] await_reg;

    // Await flags: set on HOLD entry for the strobed port, cleared by its ack; set wins
    always_ff @(posedge I_CLK_24M or posedge I_RST) begin
        if (I_RST) begin
            await_reg <= 3'b000;
        end else begin
            for (int i = 0; i < 3; i++) begin
                if (state_reg == STROBE && state_next == HOLD && gnt_reg == 2'(i))
                    await_reg[i] <= 1'b1;
                else if (I_ACK[i])
                    await_reg[i] <= 1'b0;
            end
        end
    end

    assign eligible = ~empty & ~await_reg;
`else
    logic ack_unused;
    assign ack_unused = ^I_ACK;
    assign eligible   = ~empty;
`endif

    // Round-robin pick: first eligible port at or after rr, scanned backwards so the nearest wins
    always_comb begin
        int idx;
        grant_valid = 1'b0;
        grant_idx   = rr_reg;
        for (int k = 2; k >= 0; k--) begin
            idx = (int'(rr_reg) + k) % 3;
            if (eligible[idx]) begin
                grant_valid = 1'b1;
                grant_idx   = 2'(idx);
            end
        end
    end

    // State, phase counter, pointer and grant registers
    always_ff @(posedge I_CLK_24M or posedge I_RST) begin
        if (I_RST) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
            rr_reg    <= 2'd0;
            gnt_reg   <= 2'd0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            rr_reg    <= rr_next;
            gnt_reg   <= gnt_next;
        end
    end

    // Next-state logic; the grant edge also pops the winning FIFO
    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        rr_next    = rr_reg;
        gnt_next   = gnt_reg;
        pop        = 3'b000;
        case (state_reg)
            IDLE: begin
                if (grant_valid) begin
                    state_next     = SETUP;
                    cnt_next       = '0;
                    gnt_next       = grant_idx;
                    rr_next        = (grant_idx == 2'd2) ? 2'd0 : grant_idx + 2'd1;
                    pop[grant_idx] = 1'b1;
                end
            end
            SETUP: begin
                if (cnt_reg == CNTW'(1)) begin
                    state_next = STROBE;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            STROBE: begin
                if (cnt_reg == CNTW'(STROBE_LEN - 1)) begin
                    state_next = HOLD;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            default: begin
                if (cnt_reg == CNTW'(1)) begin
                    state_next = IDLE;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
        endcase
    end

    // Latch data register: loaded with the FIFO head on the grant edge only
    always_ff @(posedge I_CLK_24M or posedge I_RST) begin
        if (I_RST) begin
            data_reg <= 8'h00;
        end else if (state_reg == IDLE && grant_valid) begin
            data_reg <= head[grant_idx];
        end
    end

    // Outputs decoded from state; only the granted strobe bit can be high
    always_comb begin
        O_4E_Q = 3'b000;
        if (state_reg == STROBE) O_4E_Q[gnt_reg] = 1'b1;
        O_BUSY = (state_reg != IDLE);
    end

    assign O_DATA = data_reg;

endmodule

// File: tb/tb_dkong3_sndlatch_ctrl.sv
// Directed bench for dkong3_sndlatch_ctrl: timing of a single transfer,
// round-robin order, FIFO full/overflow, async reset abort and ack gating.
`timescale 1ns/1ps

module tb_dkong3_sndlatch_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       wr;
    logic [1:0] sel;
    logic [7:0] dout;
    logic [2:0] ack;
    logic [7:0] data;
    logic [2:0] q;
    logic [2:0] full;
    logic [2:0] ovf;
    logic       busy;

    int n_checks = 0;
    int n_pass   = 0;
    int multi    = 0;
    int unstable = 0;

    logic [9:0] evq [$];
    logic [9:0] expq [$];

    dkong3_sndlatch_ctrl #(.DEPTH(4), .STROBE_LEN(4)) dut (
        .I_CLK_24M (clk),
        .I_RST     (rst),
        .I_MCPU_WR (wr),
        .I_PORT_SEL(sel),
        .I_MCPU_DO (dout),
        .I_ACK     (ack),
        .O_DATA    (data),
        .O_4E_Q    (q),
        .O_FULL    (full),
        .O_OVF     (ovf),
        .O_BUSY    (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Called at a negedge; the write is sampled on the following rising edge
    task automatic write(input logic [1:0] s, input logic [7:0] d);
        wr = 1'b1; sel = s; dout = d;
        @(negedge clk);
        wr = 1'b0;
    endtask

    task automatic expect_ev(input logic [1:0] p, input logic [7:0] d);
        expq.push_back({p, d});
    endtask

    task automatic check_events(input string tag);
        check({tag, "_count"}, evq.size(), expq.size());
        for (int i = 0; i < expq.size(); i++) begin
            if (i < evq.size()) check($sformatf("%s_ev%0d", tag, i), evq[i], expq[i]);
        end
        evq.delete();
        expq.delete();
    endtask

    // Strobe monitor: records (port, data) on each strobe rising edge
    initial begin
        logic [2:0] prev_q = 3'b000;
        logic [7:0] prev_d = 8'h00;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if ($countones(q) > 1) multi++;
                if (q != 0 && prev_q != 0 && data != prev_d) unstable++;
                for (int p = 0; p < 3; p++)
                    if (q[p] && !prev_q[p]) evq.push_back({2'(p), data});
            end
            prev_q = q;
            prev_d = data;
        end
    end

    initial begin
        rst = 1'b1; wr = 1'b0; sel = 2'd0; dout = 8'h00; ack = 3'b111;
        cyc(3);
        check("rst_data", data, 8'h00);
        check("rst_q", q, 3'b000);
        check("rst_busy", busy, 1'b0);
        check("rst_full", full, 3'b000);
        check("rst_ovf", ovf, 3'b000);
        rst = 1'b0;

        // Single transfer timing
        write(2'd1, 8'hA5);
        check("t1_busy_e0", busy, 1'b0);
        check("t1_data_e0", data, 8'h00);
        cyc(1);
        check("t1_data_e1", data, 8'hA5);
        check("t1_busy_e1", busy, 1'b1);
        check("t1_q_e1", q, 3'b000);
        cyc(1);
        check("t1_q_e2", q, 3'b000);
        for (int i = 0; i < 4; i++) begin
            cyc(1);
            check($sformatf("t1_q_e%0d", 3 + i), q, 3'b010);
        end
        cyc(1);
        check("t1_q_e7", q, 3'b000);
        check("t1_busy_e7", busy, 1'b1);
        cyc(1);
        check("t1_busy_e8", busy, 1'b1);
        cyc(1);
        check("t1_busy_e9", busy, 1'b0);
        expect_ev(2'd1, 8'hA5);
        check_events("t1");

        // Three ports back to back: round-robin order
        write(2'd0, 8'h11);
        write(2'd1, 8'h22);
        write(2'd2, 8'h33);
        cyc(60);
        expect_ev(2'd0, 8'h11);
        expect_ev(2'd1, 8'h22);
        expect_ev(2'd2, 8'h33);
        check_events("t2");
        check("t2_busy", busy, 1'b0);

        // Fill port 2 while the FSM is busy with port 0
        write(2'd0, 8'h77);
        write(2'd2, 8'hC0);
        write(2'd2, 8'hC1);
        write(2'd2, 8'hC2);
        write(2'd2, 8'hC3);
        check("t3_full4", full, 3'b100);
        check("t3_ovf4", ovf, 3'b000);
        write(2'd2, 8'hC4);
        check("t3_full5", full, 3'b100);
        check("t3_ovf5", ovf, 3'b100);
        write(2'd3, 8'hEE);
        cyc(100);
        expect_ev(2'd0, 8'h77);
        expect_ev(2'd2, 8'hC0);
        expect_ev(2'd2, 8'hC1);
        expect_ev(2'd2, 8'hC2);
        expect_ev(2'd2, 8'hC3);
        check_events("t3");
        check("t3_full_end", full, 3'b000);
        check("t3_ovf_end", ovf, 3'b100);

        // Reset mid-strobe aborts the transfer and drops queued bytes
        rst = 1'b1;
        cyc(1);
        check("t4_ovf_clr", ovf, 3'b000);
        rst = 1'b0;
        write(2'd0, 8'h55);
        write(2'd0, 8'h66);
        write(2'd0, 8'h88);
        for (int i = 0; i < 20 && !q[0]; i++) cyc(1);
        check("t4_strobe_seen", q[0], 1'b1);
        #2 rst = 1'b1;
        #1;
        check("t4_rst_q", q, 3'b000);
        check("t4_rst_data", data, 8'h00);
        check("t4_rst_busy", busy, 1'b0);
        check("t4_rst_full", full, 3'b000);
        @(negedge clk);
        rst = 1'b0;
        cyc(40);
        write(2'd1, 8'h9A);
        cyc(1);
        check("t4_first_wr", data, 8'h9A);
        cyc(20);
        expect_ev(2'd0, 8'h55);
        expect_ev(2'd1, 8'h9A);
        check_events("t4");

        // Ack gating (ignored when the feature is not built)
        ack = 3'b000;
        write(2'd0, 8'h01);
        write(2'd0, 8'h02);
        cyc(40);
`ifdef DK3_SNDLATCH_ACKWAIT_EN
        expect_ev(2'd0, 8'h01);
        check_events("t5a");
        ack = 3'b001;
        cyc(1);
        ack = 3'b000;
        cyc(2);
        check("t5_q_a2", q, 3'b000);
        cyc(1);
        check("t5_q_a3", q, 3'b001);
        check("t5_data", data, 8'h02);
        cyc(20);
        expect_ev(2'd0, 8'h02);
        check_events("t5b");
`else
        expect_ev(2'd0, 8'h01);
        expect_ev(2'd0, 8'h02);
        check_events("t5");
`endif

        check("onehot", multi, 0);
        check("data_stable", unstable, 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
